interrupt_sequencer: RTL and testbench

Parametrised interrupt and reset entry sequencer for the 6502 core. It sits beside `instruction_decode` and takes over the address and data bus at instruction boundaries to run the reset, NMI and IRQ entry sequences: push PCH, PCL and P, fetch the vector, load the PC. It supports N maskable IRQ sources with fixed priority, an edge-detected NMI, and configurable vector and stack-page addresses. While `busy` is high, the decoder holds in its idle state.

---
 rtl/interrupt_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: runs the reset, NMI and IRQ entry sequences for the 6502 core.
// At an instruction boundary it takes the bus from the decoder. For NMI and IRQ it
// pushes PCH, PCL and P, then reads the vector and hands the new PC back.
module interrupt_sequencer #(
  parameter int          N_IRQ        = 4,
  parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE   = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_enable,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             nmi,
  input  logic             i_flag,
  input  logic             insn_boundary,
  input  logic [15:0]      pc_in,
  input  logic [7:0]       status_in,
  input  logic [7:0]       sp_in,
  input  logic [7:0]       data_in,
  output logic             busy,
  output logic [15:0]      memory_address,
  output logic             rw,
  output logic [7:0]       data_out,
  output logic             sp_dec,
  output logic             pc_load,
  output logic [15:0]      pc_value,
  output logic             set_i_flag,
  output logic [N_IRQ-1:0] irq_ack,
  output logic [1:0]       irq_cause
);

  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_RESET = 2'b01;
  localparam logic [1:0] CAUSE_NMI   = 2'b10;
  localparam logic [1:0] CAUSE_IRQ   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_PCH,
    PUSH_PCL,
    PUSH_P,
    VEC_LO,
    VEC_HI,
    LOAD_PC
  } state_t;

  state_t          state;
  logic [1:0]      cause;
  logic            nmi_pending;
  logic            nmi_prev;
  logic [7:0]      vec_lo;
  logic [7:0]      vec_hi;
  logic [ID_W-1:0] irq_id;

  logic [N_IRQ-1:0] irq_active;
  logic             irq_req;
  logic [ID_W-1:0]  irq_pick;
  logic             take;
  logic             take_nmi;
  logic [15:0]      vector;
  logic [15:0]      vector_next;
  logic [15:0]      stack_address;
  logic [7:0]       pushed_status;

  assign irq_active    = irq_src & irq_mask;
  assign irq_req       = (|irq_active) & ~i_flag;
  assign take          = ~rst & clk_enable & insn_boundary & (state == IDLE) & (nmi_pending | irq_req);
  assign take_nmi      = take & nmi_pending;
  assign vector_next   = vector + 16'd1;
  assign stack_address = {STACK_PAGE, sp_in};
  assign pushed_status = {status_in[7:6], 1'b1, 1'b0, status_in[3:0]};

  // Lowest-numbered enabled source wins, so scan from the top down and let lower indices overwrite
  always_comb begin
    irq_pick = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (irq_active[i]) irq_pick = ID_W'(i);
    end
  end

  // The vector address follows the cause latched when the sequence started
  always_comb begin
    case (cause)
      CAUSE_NMI: vector = NMI_VECTOR;
      CAUSE_IRQ: vector = IRQ_VECTOR;
      default:   vector = RESET_VECTOR;
    endcase
  end

  // Sequencer state, cause, NMI edge detector and vector latch; a pending NMI set beats its own clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= VEC_LO;
      cause       <= CAUSE_RESET;
      nmi_pending <= 1'b0;
      nmi_prev    <= 1'b0;
      vec_lo      <= 8'h00;
      vec_hi      <= 8'h00;
      irq_id      <= '0;
    end else if (clk_enable) begin
      nmi_prev <= nmi;
      if (nmi && !nmi_prev) begin
        nmi_pending <= 1'b1;
      end else if (take_nmi) begin
        nmi_pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (take) begin
            state <= PUSH_PCH;
            if (take_nmi) begin
              cause <= CAUSE_NMI;
            end else begin
              cause  <= CAUSE_IRQ;
              irq_id <= irq_pick;
            end
          end
        end
        PUSH_PCH: state <= PUSH_PCL;
        PUSH_PCL: state <= PUSH_P;
        PUSH_P:   state <= VEC_LO;
        VEC_LO: begin
          vec_lo <= data_in;
          state  <= VEC_HI;
        end
        VEC_HI: begin
          vec_hi <= data_in;
          state  <= LOAD_PC;
        end
        LOAD_PC: begin
          state <= IDLE;
          cause <= CAUSE_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus and strobe outputs decoded from the current state; writes and strobes only fire on enabled cycles
  always_comb begin
    busy           = (state != IDLE) | take;
    memory_address = 16'h0000;
    rw             = 1'b1;
    data_out       = 8'h00;
    sp_dec         = 1'b0;
    pc_load        = 1'b0;
    pc_value       = 16'h0000;
    set_i_flag     = 1'b0;
    irq_ack        = '0;
    irq_cause      = cause;

    if (rst) begin
      busy           = 1'b1;
      irq_cause      = CAUSE_RESET;
      memory_address = RESET_VECTOR;
    end else begin
      case (state)
        PUSH_PCH: begin
          memory_address = stack_address;
          rw             = ~clk_enable;
          data_out       = pc_in[15:8];
          sp_dec         = clk_enable;
        end
        PUSH_PCL: begin
          memory_address = stack_address;
          rw             = ~clk_enable;
          data_out       = pc_in[7:0];
          sp_dec         = clk_enable;
        end
        PUSH_P: begin
          memory_address = stack_address;
          rw             = ~clk_enable;
          data_out       = pushed_status;
          sp_dec         = clk_enable;
        end
        VEC_LO: memory_address = vector;
        VEC_HI: memory_address = vector_next;
        LOAD_PC: begin
          pc_load    = clk_enable;
          pc_value   = {vec_hi, vec_lo};
          set_i_flag = clk_enable;
          if (clk_enable && cause == CAUSE_IRQ) begin
            irq_ack = N_IRQ'(1) << irq_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed scenarios for interrupt_sequencer with hand-computed bus traces.
module tb_interrupt_sequencer;

  logic        clk;
  logic        rst;
  logic        clk_enable;
  logic [3:0]  irq_src;
  logic [3:0]  irq_mask;
  logic        nmi;
  logic        i_flag;
  logic        insn_boundary;
  logic [15:0] pc_in;
  logic [7:0]  status_in;
  logic [7:0]  sp_in;
  logic [7:0]  data_in;
  logic        busy;
  logic [15:0] memory_address;
  logic        rw;
  logic [7:0]  data_out;
  logic        sp_dec;
  logic        pc_load;
  logic [15:0] pc_value;
  logic        set_i_flag;
  logic [3:0]  irq_ack;
  logic [1:0]  irq_cause;

  logic [26:0] bus_obs;
  logic [23:0] ld_obs;

  int checks;
  int errors;

  interrupt_sequencer #(
    .N_IRQ       (4),
    .NMI_VECTOR  (16'hFFFA),
    .RESET_VECTOR(16'hFFFC),
    .IRQ_VECTOR  (16'hFFFE),
    .STACK_PAGE  (8'h01)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_enable    (clk_enable),
    .irq_src       (irq_src),
    .irq_mask      (irq_mask),
    .nmi           (nmi),
    .i_flag        (i_flag),
    .insn_boundary (insn_boundary),
    .pc_in         (pc_in),
    .status_in     (status_in),
    .sp_in         (sp_in),
    .data_in       (data_in),
    .busy          (busy),
    .memory_address(memory_address),
    .rw            (rw),
    .data_out      (data_out),
    .sp_dec        (sp_dec),
    .pc_load       (pc_load),
    .pc_value      (pc_value),
    .set_i_flag    (set_i_flag),
    .irq_ack       (irq_ack),
    .irq_cause     (irq_cause)
  );

  // Bus and load-side outputs bundled so one comparison covers a whole cycle
  assign bus_obs = {busy, rw, sp_dec, memory_address, data_out};
  assign ld_obs  = {pc_load, set_i_flag, pc_value, irq_ack, irq_cause};

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector ROM: reset -> 1234, NMI -> 9000, IRQ -> 8000
  always_comb begin
    case (memory_address)
      16'hFFFA: data_in = 8'h00;
      16'hFFFB: data_in = 8'h90;
      16'hFFFC: data_in = 8'h34;
      16'hFFFD: data_in = 8'h12;
      16'hFFFE: data_in = 8'h00;
      16'hFFFF: data_in = 8'h80;
      default:  data_in = 8'hEE;
    endcase
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reset hold, then the three-cycle reset vector fetch
  task automatic test_reset();
    rst = 1'b1; clk_enable = 1'b1; irq_src = 4'h0; irq_mask = 4'h0; nmi = 1'b0;
    i_flag = 1'b1; insn_boundary = 1'b0; pc_in = 16'h0000; status_in = 8'h00; sp_in = 8'hFF;
    #1;
    checks++;
    if (bus_obs !== {1'b1, 1'b1, 1'b0, 16'hFFFC, 8'h00}) begin
      errors++; $display("[TB] FAIL reset_hold_bus got %h expected %h", bus_obs, {1'b1, 1'b1, 1'b0, 16'hFFFC, 8'h00});
    end
    checks++;
    if (ld_obs !== {1'b0, 1'b0, 16'h0000, 4'h0, 2'b01}) begin
      errors++; $display("[TB] FAIL reset_hold_load got %h expected %h", ld_obs, {1'b0, 1'b0, 16'h0000, 4'h0, 2'b01});
    end
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (bus_obs !== {1'b1, 1'b1, 1'b0, 16'hFFFC, 8'h00}) begin
      errors++; $display("[TB] FAIL reset_vec_lo got %h expected %h", bus_obs, {1'b1, 1'b1, 1'b0, 16'hFFFC, 8'h00});
    end
    cycle();
    checks++;
    if (bus_obs !== {1'b1, 1'b1, 1'b0, 16'hFFFD, 8'h00}) begin
      errors++; $display("[TB] FAIL reset_vec_hi got %h expected %h", bus_obs, {1'b1, 1'b1, 1'b0, 16'hFFFD, 8'h00});
    end
    cycle();
    checks++;
    if (ld_obs !== {1'b1, 1'b1, 16'h1234, 4'h0, 2'b01}) begin
      errors++; $display("[TB] FAIL reset_load_pc got %h expected %h", ld_obs, {1'b1, 1'b1, 16'h1234, 4'h0, 2'b01});
    end
    cycle();
    checks++;
    if ({busy, irq_cause} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_idle got %b expected %b", {busy, irq_cause}, 3'b000);
    end
  endtask

  // Full IRQ entry trace with two sources pending, then no re-entry once I is set
  task automatic test_irq_priority();
    logic [26:0] eb [8];
    logic [23:0] el [8];
    logic        dec;
    eb[0] = {1'b1, 1'b1, 1'b0, 16'h0000, 8'h00};
    eb[1] = {1'b1, 1'b0, 1'b1, 16'h01FF, 8'hC0};
    eb[2] = {1'b1, 1'b0, 1'b1, 16'h01FE, 8'h05};
    eb[3] = {1'b1, 1'b0, 1'b1, 16'h01FD, 8'hA1};
    eb[4] = {1'b1, 1'b1, 1'b0, 16'hFFFE, 8'h00};
    eb[5] = {1'b1, 1'b1, 1'b0, 16'hFFFF, 8'h00};
    eb[6] = {1'b1, 1'b1, 1'b0, 16'h0000, 8'h00};
    eb[7] = {1'b0, 1'b1, 1'b0, 16'h0000, 8'h00};
    el[0] = {1'b0, 1'b0, 16'h0000, 4'h0, 2'b00};
    for (int k = 1; k < 6; k++) el[k] = {1'b0, 1'b0, 16'h0000, 4'h0, 2'b11};
    el[6] = {1'b1, 1'b1, 16'h8000, 4'b0010, 2'b11};
    el[7] = {1'b0, 1'b0, 16'h0000, 4'h0, 2'b00};

    irq_src = 4'b0110; irq_mask = 4'b1111; i_flag = 1'b0;
    pc_in = 16'hC005; sp_in = 8'hFF; status_in = 8'hA1; insn_boundary = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus_obs !== eb[k]) begin
        errors++; $display("[TB] FAIL irq_bus_%0d got %h expected %h", k, bus_obs, eb[k]);
      end
      checks++;
      if (ld_obs !== el[k]) begin
        errors++; $display("[TB] FAIL irq_load_%0d got %h expected %h", k, ld_obs, el[k]);
      end
      if (k < 7) begin
        dec = sp_dec;
        cycle();
        if (dec) sp_in = sp_in - 8'd1;
        insn_boundary = (k == 6);
        if (k == 6) i_flag = 1'b1;
        #1;
      end
    end
    irq_src = 4'h0; insn_boundary = 1'b0;
  endtask

  // Mask and I flag each block entry; unmasking starts a sequence at the next boundary
  task automatic test_masking();
    int  busy_seen;
    bit  found;
    cycle();
    irq_src = 4'b0001; irq_mask = 4'b0000; i_flag = 1'b0; insn_boundary = 1'b1;
    busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      #1; if (busy) busy_seen++;
      cycle();
    end
    checks++;
    if (busy_seen !== 0) begin
      errors++; $display("[TB] FAIL mask_blocks got %0d busy cycles expected 0", busy_seen);
    end
    irq_mask = 4'b0001; i_flag = 1'b1;
    busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      #1; if (busy) busy_seen++;
      cycle();
    end
    checks++;
    if (busy_seen !== 0) begin
      errors++; $display("[TB] FAIL iflag_blocks got %0d busy cycles expected 0", busy_seen);
    end
    i_flag = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("[TB] FAIL unmask_take got %b expected 1", busy);
    end
    cycle();
    insn_boundary = 1'b0;
    #1;
    checks++;
    if (irq_cause !== 2'b11) begin
      errors++; $display("[TB] FAIL unmask_cause got %b expected 11", irq_cause);
    end
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (pc_load) found = 1'b1;
    end
    checks++;
    if ({found, ld_obs} !== {1'b1, 1'b1, 1'b1, 16'h8000, 4'b0001, 2'b11}) begin
      errors++; $display("[TB] FAIL unmask_load got %h expected %h", {found, ld_obs}, {1'b1, 1'b1, 1'b1, 16'h8000, 4'b0001, 2'b11});
    end
    cycle();
    i_flag = 1'b1; irq_src = 4'h0;
  endtask

  // NMI edge pending at the boundary wins over a simultaneous IRQ
  task automatic test_nmi_over_irq();
    int busy_seen;
    irq_src = 4'b1000; irq_mask = 4'b1111; i_flag = 1'b0; insn_boundary = 1'b0; nmi = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL nmi_no_boundary got %b expected 0", busy);
    end
    cycle();
    insn_boundary = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("[TB] FAIL nmi_take got %b expected 1", busy);
    end
    cycle();
    insn_boundary = 1'b0;
    #1;
    checks++;
    if (irq_cause !== 2'b10) begin
      errors++; $display("[TB] FAIL nmi_cause got %b expected 10", irq_cause);
    end
    cycle(); cycle(); cycle();
    checks++;
    if ({rw, memory_address} !== {1'b1, 16'hFFFA}) begin
      errors++; $display("[TB] FAIL nmi_vec_lo got %h expected %h", {rw, memory_address}, {1'b1, 16'hFFFA});
    end
    cycle();
    checks++;
    if ({rw, memory_address} !== {1'b1, 16'hFFFB}) begin
      errors++; $display("[TB] FAIL nmi_vec_hi got %h expected %h", {rw, memory_address}, {1'b1, 16'hFFFB});
    end
    cycle();
    checks++;
    if (ld_obs !== {1'b1, 1'b1, 16'h9000, 4'h0, 2'b10}) begin
      errors++; $display("[TB] FAIL nmi_load got %h expected %h", ld_obs, {1'b1, 1'b1, 16'h9000, 4'h0, 2'b10});
    end
    cycle();
    i_flag = 1'b1; insn_boundary = 1'b1;
    busy_seen = 0;
    for (int k = 0; k < 8; k++) begin
      #1; if (busy) busy_seen++;
      cycle();
    end
    checks++;
    if (busy_seen !== 0) begin
      errors++; $display("[TB] FAIL nmi_no_irq_after got %0d busy cycles expected 0", busy_seen);
    end
    nmi = 1'b0; irq_src = 4'h0; insn_boundary = 1'b0;
    cycle();
  endtask

  // NMI edge mid-IRQ: IRQ finishes first, NMI follows at the next boundary, held NMI gives one entry
  task automatic test_nmi_during_seq();
    bit found;
    int busy_seen;
    irq_src = 4'b0001; irq_mask = 4'b1111; i_flag = 1'b0; insn_boundary = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("[TB] FAIL nseq_irq_take got %b expected 1", busy);
    end
    cycle();
    insn_boundary = 1'b0;
    cycle();
    nmi = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (pc_load) found = 1'b1;
    end
    checks++;
    if ({found, ld_obs} !== {1'b1, 1'b1, 1'b1, 16'h8000, 4'b0001, 2'b11}) begin
      errors++; $display("[TB] FAIL nseq_irq_load got %h expected %h", {found, ld_obs}, {1'b1, 1'b1, 1'b1, 16'h8000, 4'b0001, 2'b11});
    end
    cycle();
    i_flag = 1'b1; insn_boundary = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL nseq_wait_boundary got %b expected 0", busy);
    end
    cycle();
    insn_boundary = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("[TB] FAIL nseq_nmi_take got %b expected 1", busy);
    end
    cycle();
    insn_boundary = 1'b0;
    #1;
    checks++;
    if (irq_cause !== 2'b10) begin
      errors++; $display("[TB] FAIL nseq_nmi_cause got %b expected 10", irq_cause);
    end
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (pc_load) found = 1'b1;
    end
    checks++;
    if ({found, ld_obs} !== {1'b1, 1'b1, 1'b1, 16'h9000, 4'h0, 2'b10}) begin
      errors++; $display("[TB] FAIL nseq_nmi_load got %h expected %h", {found, ld_obs}, {1'b1, 1'b1, 1'b1, 16'h9000, 4'h0, 2'b10});
    end
    cycle();
    insn_boundary = 1'b1;
    busy_seen = 0;
    for (int k = 0; k < 10; k++) begin
      #1; if (busy) busy_seen++;
      cycle();
    end
    checks++;
    if (busy_seen !== 0) begin
      errors++; $display("[TB] FAIL nseq_held_nmi got %0d busy cycles expected 0", busy_seen);
    end
    nmi = 1'b0; irq_src = 4'h0; insn_boundary = 1'b0;
    cycle();
  endtask

  // Reset during VEC_HI of an IRQ aborts it without load or ack, then runs the reset fetch
  task automatic test_reset_mid_op();
    int ack_seen;
    int load_seen;
    i_flag = 1'b0; irq_src = 4'b0100; irq_mask = 4'b1111; insn_boundary = 1'b1;
    #1;
    cycle();
    insn_boundary = 1'b0;
    cycle(); cycle(); cycle(); cycle();
    checks++;
    if ({irq_cause, memory_address} !== {2'b11, 16'hFFFF}) begin
      errors++; $display("[TB] FAIL rmid_in_vec_hi got %h expected %h", {irq_cause, memory_address}, {2'b11, 16'hFFFF});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, ld_obs} !== {1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 2'b01}) begin
      errors++; $display("[TB] FAIL rmid_during_rst got %h expected %h", {busy, ld_obs}, {1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 2'b01});
    end
    cycle();
    rst = 1'b0; i_flag = 1'b1; irq_src = 4'h0;
    ack_seen = 0; load_seen = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (irq_ack !== 4'h0) ack_seen++;
      if (pc_load) load_seen++;
      if (k == 2) begin
        checks++;
        if (ld_obs !== {1'b1, 1'b1, 16'h1234, 4'h0, 2'b01}) begin
          errors++; $display("[TB] FAIL rmid_reset_load got %h expected %h", ld_obs, {1'b1, 1'b1, 16'h1234, 4'h0, 2'b01});
        end
      end
      cycle();
    end
    checks++;
    if ({ack_seen, load_seen} !== {32'd0, 32'd1}) begin
      errors++; $display("[TB] FAIL rmid_counts got ack %0d load %0d expected ack 0 load 1", ack_seen, load_seen);
    end
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL rmid_idle got %b expected 0", busy);
    end
  endtask

  // Three stalled cycles in PUSH_P yield exactly one P write and one sp_dec for it
  task automatic test_clk_enable_stall();
    int         writes;
    int         decs;
    int         loads;
    logic [7:0] pushed_p;
    logic [3:0] ack_at_load;
    logic       dec;
    sp_in = 8'hFF; pc_in = 16'hC005; status_in = 8'h91;
    irq_src = 4'b0001; irq_mask = 4'b1111; i_flag = 1'b0; insn_boundary = 1'b1; clk_enable = 1'b1;
    writes = 0; decs = 0; loads = 0; pushed_p = 8'h00; ack_at_load = 4'h0;
    for (int k = 0; k < 14; k++) begin
      #1;
      if (rw === 1'b0) writes++;
      if (sp_dec) decs++;
      if (pc_load) begin
        loads++;
        ack_at_load = irq_ack;
      end
      if (rw === 1'b0 && memory_address == 16'h01FD) pushed_p = data_out;
      if (k == 4) begin
        checks++;
        if ({rw, sp_dec, memory_address} !== {1'b1, 1'b0, 16'h01FD}) begin
          errors++; $display("[TB] FAIL stall_hold got %h expected %h", {rw, sp_dec, memory_address}, {1'b1, 1'b0, 16'h01FD});
        end
      end
      dec = sp_dec;
      cycle();
      if (dec) sp_in = sp_in - 8'd1;
      insn_boundary = 1'b0;
      clk_enable = !(k >= 2 && k <= 4);
    end
    checks++;
    if ({writes, decs, loads} !== {32'd3, 32'd3, 32'd1}) begin
      errors++; $display("[TB] FAIL stall_counts got w%0d d%0d l%0d expected w3 d3 l1", writes, decs, loads);
    end
    checks++;
    if ({pushed_p, ack_at_load} !== {8'hA1, 4'b0001}) begin
      errors++; $display("[TB] FAIL stall_push_ack got %h expected %h", {pushed_p, ack_at_load}, {8'hA1, 4'b0001});
    end
    clk_enable = 1'b1; irq_src = 4'h0; i_flag = 1'b1;
  endtask

  // Scenario sequence and summary
  initial begin
    checks = 0;
    errors = 0;
    $display("[TB] interrupt_sequencer directed tests");
    test_reset();
    test_irq_priority();
    test_masking();
    test_nmi_over_irq();
    test_nmi_during_seq();
    test_reset_mid_op();
    test_clk_enable_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
